// File: rtl/mem_pipe_responder.sv
// mem_pipe_responder: pipelined multi-cycle word memory used as the responder
// on the CPU instruction/data memory interface.
//
// Optional build macro: MEMRESP_ALIGN_CHK_EN
//   When defined, an odd byte address is treated as misaligned:
//   - writes to it are dropped;
//   - reads from it return 16'h0000 with misalign_err raised on the strobe.
//   When undefined, addr[0] is ignored and misalign_err does not exist.
//
// Request/response protocol:
//   A request is presented by holding enable high for one cycle. It is
//   accepted on that rising edge unconditionally; there is no ready and no
//   backpressure. Writes commit at the accepting edge and produce no
//   response. Each read produces exactly one data_valid strobe LATENCY
//   cycles after its request cycle. Reads return in order. data_out is
//   meaningful only while data_valid is high and otherwise holds the last
//   returned word.
//
// LATENCY must lie in 1..8. ADDR_W must exceed DEPTH_W. Address bits above
// DEPTH_W are ignored, so addresses alias onto the same word.

module mem_pipe_responder #(
  parameter int ADDR_W  = 16,
  parameter int DEPTH_W = 15,
  parameter int LATENCY = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              wr,
  input  logic [ADDR_W-1:0] addr,
  input  logic [15:0]       data_in,
  output logic [15:0]       data_out,
  output logic              data_valid,
  output logic [3:0]        rd_outstanding
`ifdef MEMRESP_ALIGN_CHK_EN
  ,
  output logic              misalign_err
`endif
);

  localparam int WORDS = 1 << DEPTH_W;

  // Word storage. Deliberately not reset: contents survive rst_n.
  logic [15:0] mem [WORDS];

  logic [DEPTH_W-1:0] word_idx;
  logic               rd_accept;
  logic               wr_accept;
  logic [15:0]        rd_word;
  logic               unused_addr;

  // Per-stage pipeline state. Stage LATENCY-1 drives the outputs.
  logic [LATENCY-1:0] pipe_v;
  logic [15:0]        pipe_d [LATENCY];

  assign word_idx    = addr[DEPTH_W:1];
  // Bits outside the word index are ignored in the default build.
  assign unused_addr = ^addr;

`ifdef MEMRESP_ALIGN_CHK_EN
  logic               misaligned;
  logic [LATENCY-1:0] pipe_m;

  assign misaligned = addr[0];
  assign wr_accept  = enable & wr & ~misaligned;
  assign rd_accept  = enable & ~wr;
`else
  assign wr_accept  = enable & wr;
  assign rd_accept  = enable & ~wr;
`endif

  // Array sample for the read being accepted. A write accepted on an earlier
  // edge is already in the array, so consecutive write-then-read sees it.
  always_comb begin
    rd_word = mem[word_idx];
`ifdef MEMRESP_ALIGN_CHK_EN
    if (misaligned) begin
      rd_word = 16'h0000;
    end
`endif
  end

  // Commit accepted writes into the array at the accepting edge.
  always_ff @(posedge clk) begin
    if (wr_accept) begin
      mem[word_idx] <= data_in;
    end
  end

  // Read pipeline: valid bits shift every edge; data only moves with a valid
  // bit, so the last stage holds the last returned word between strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_v <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        pipe_d[i] <= 16'h0000;
      end
    end else begin
      pipe_v[0] <= rd_accept;
      if (rd_accept) begin
        pipe_d[0] <= rd_word;
      end
      for (int i = 1; i < LATENCY; i++) begin
        pipe_v[i] <= pipe_v[i-1];
        if (pipe_v[i-1]) begin
          pipe_d[i] <= pipe_d[i-1];
        end
      end
    end
  end

`ifdef MEMRESP_ALIGN_CHK_EN
  // Misalignment tag travels alongside the read it belongs to.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_m <= '0;
    end else begin
      if (rd_accept) begin
        pipe_m[0] <= misaligned;
      end
      for (int i = 1; i < LATENCY; i++) begin
        if (pipe_v[i-1]) begin
          pipe_m[i] <= pipe_m[i-1];
        end
      end
    end
  end

  assign misalign_err = pipe_v[LATENCY-1] & pipe_m[LATENCY-1];
`endif

  // Count reads accepted but not yet returned; a return retires its read at
  // the edge that ends the strobe cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_outstanding <= 4'd0;
    end else begin
      case ({rd_accept, pipe_v[LATENCY-1]})
        2'b10:   rd_outstanding <= rd_outstanding + 4'd1;
        2'b01:   rd_outstanding <= rd_outstanding - 4'd1;
        default: rd_outstanding <= rd_outstanding;
      endcase
    end
  end

  assign data_valid = pipe_v[LATENCY-1];
  assign data_out   = pipe_d[LATENCY-1];

endmodule

// File: tb/tb_mem_pipe_responder.sv
// Directed testbench for mem_pipe_responder: a LATENCY=4 instance (main
// checks) and a LATENCY=1 instance (minimum latency and interleaving).
// Honours MEMRESP_ALIGN_CHK_EN when the build defines it.

module tb_mem_pipe_responder;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // LATENCY=4 instance signals
  logic        en4 = 1'b0;
  logic        wr4 = 1'b0;
  logic [15:0] addr4 = '0;
  logic [15:0] din4 = '0;
  logic [15:0] dout4;
  logic        dv4;
  logic [3:0]  outst4;

  // LATENCY=1 instance signals
  logic        en1 = 1'b0;
  logic        wr1 = 1'b0;
  logic [15:0] addr1 = '0;
  logic [15:0] din1 = '0;
  logic [15:0] dout1;
  logic        dv1;
  logic [3:0]  outst1;

`ifdef MEMRESP_ALIGN_CHK_EN
  logic        mis4;
  logic        mis1;
`endif

  mem_pipe_responder #(.ADDR_W(16), .DEPTH_W(15), .LATENCY(4)) u_dut4 (
    .clk            (clk),
    .rst_n          (rst_n),
    .enable         (en4),
    .wr             (wr4),
    .addr           (addr4),
    .data_in        (din4),
    .data_out       (dout4),
    .data_valid     (dv4),
    .rd_outstanding (outst4)
`ifdef MEMRESP_ALIGN_CHK_EN
    ,
    .misalign_err   (mis4)
`endif
  );

  mem_pipe_responder #(.ADDR_W(16), .DEPTH_W(15), .LATENCY(1)) u_dut1 (
    .clk            (clk),
    .rst_n          (rst_n),
    .enable         (en1),
    .wr             (wr1),
    .addr           (addr1),
    .data_in        (din1),
    .data_out       (dout1),
    .data_valid     (dv1),
    .rd_outstanding (outst1)
`ifdef MEMRESP_ALIGN_CHK_EN
    ,
    .misalign_err   (mis1)
`endif
  );

  int tests = 0;
  int fails = 0;

  // ---------------- helpers ----------------
  // Advance past the next rising edge; outputs are sampled 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks (LATENCY=4) ----------------
  task automatic wr4_word(input logic [15:0] a, input logic [15:0] d);
    en4 = 1'b1; wr4 = 1'b1; addr4 = a; din4 = d;
    step();
    en4 = 1'b0; wr4 = 1'b0;
  endtask

  // Single read with full latency check: silent for 3 sampled cycles,
  // strobe on the 4th, silent again afterwards with data held.
  task automatic rd4_check(input string tag, input logic [15:0] a,
                           input logic [15:0] exp_d, input logic exp_mis);
    en4 = 1'b1; wr4 = 1'b0; addr4 = a;
    step();
    en4 = 1'b0;
    chk({tag, "_dv_c1"}, dv4, 1'b0);
    chk({tag, "_outst_c1"}, outst4, 4'd1);
    step();
    chk({tag, "_dv_c2"}, dv4, 1'b0);
    step();
    chk({tag, "_dv_c3"}, dv4, 1'b0);
    step();
    chk({tag, "_dv_c4"}, dv4, 1'b1);
    chk({tag, "_data"}, dout4, exp_d);
`ifdef MEMRESP_ALIGN_CHK_EN
    chk({tag, "_mis"}, mis4, exp_mis);
`else
    if (exp_mis) chk({tag, "_mis_unexpected"}, 1'b0, 1'b1);
`endif
    step();
    chk({tag, "_dv_c5"}, dv4, 1'b0);
    chk({tag, "_hold"}, dout4, exp_d);
    chk({tag, "_outst_end"}, outst4, 4'd0);
`ifdef MEMRESP_ALIGN_CHK_EN
    chk({tag, "_mis_end"}, mis4, 1'b0);
`endif
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    // Reset state
    rst_n = 1'b0;
    step();
    step();
    chk("rst_dv4", dv4, 1'b0);
    chk("rst_dout4", dout4, 16'h0000);
    chk("rst_outst4", outst4, 4'd0);
    chk("rst_dv1", dv1, 1'b0);
    chk("rst_outst1", outst1, 4'd0);
    rst_n = 1'b1;
    step();

    // Write produces no response during 6 idle cycles
    wr4_word(16'h0010, 16'hBEEF);
    for (int i = 0; i < 6; i++) begin
      chk("wr_idle_dv", dv4, 1'b0);
      chk("wr_idle_outst", outst4, 4'd0);
      step();
    end
    rd4_check("rd_beef", 16'h0010, 16'hBEEF, 1'b0);

    // Read immediately after a write returns the new word
    wr4_word(16'h0020, 16'h1234);
    rd4_check("raw_1234", 16'h0020, 16'h1234, 1'b0);

    // Back-to-back reads, in order, no gaps
    wr4_word(16'h0000, 16'h0001);
    wr4_word(16'h0002, 16'h0002);
    wr4_word(16'h0004, 16'h0003);
    wr4_word(16'h0006, 16'h0004);
    en4 = 1'b1; wr4 = 1'b0;
    addr4 = 16'h0000; step();
    chk("b2b_dv_r1", dv4, 1'b0);
    chk("b2b_outst_r1", outst4, 4'd1);
    addr4 = 16'h0002; step();
    chk("b2b_dv_r2", dv4, 1'b0);
    chk("b2b_outst_r2", outst4, 4'd2);
    addr4 = 16'h0004; step();
    chk("b2b_dv_r3", dv4, 1'b0);
    chk("b2b_outst_r3", outst4, 4'd3);
    addr4 = 16'h0006; step();
    en4 = 1'b0;
    chk("b2b_dv_1", dv4, 1'b1);
    chk("b2b_d_1", dout4, 16'h0001);
    chk("b2b_outst_peak", outst4, 4'd4);
    step();
    chk("b2b_dv_2", dv4, 1'b1);
    chk("b2b_d_2", dout4, 16'h0002);
    chk("b2b_outst_3", outst4, 4'd3);
    step();
    chk("b2b_dv_3", dv4, 1'b1);
    chk("b2b_d_3", dout4, 16'h0003);
    chk("b2b_outst_2", outst4, 4'd2);
    step();
    chk("b2b_dv_4", dv4, 1'b1);
    chk("b2b_d_4", dout4, 16'h0004);
    chk("b2b_outst_1", outst4, 4'd1);
    step();
    chk("b2b_dv_end", dv4, 1'b0);
    chk("b2b_hold", dout4, 16'h0004);
    chk("b2b_outst_0", outst4, 4'd0);

    // Reset while 3 reads are in flight
    en4 = 1'b1; wr4 = 1'b0;
    addr4 = 16'h0010; step();
    addr4 = 16'h0020; step();
    addr4 = 16'h0000; step();
    en4 = 1'b0;
    chk("mid_outst_pre", outst4, 4'd3);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_outst", outst4, 4'd0);
    chk("mid_rst_dv", dv4, 1'b0);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("mid_after_dv", dv4, 1'b0);
      chk("mid_after_outst", outst4, 4'd0);
    end
    rd4_check("persist_beef", 16'h0010, 16'hBEEF, 1'b0);

    // Odd byte address
    wr4_word(16'h0002, 16'hAAAA);
`ifdef MEMRESP_ALIGN_CHK_EN
    rd4_check("mis_rd", 16'h0003, 16'h0000, 1'b1);
    wr4_word(16'h0003, 16'h5555);
    rd4_check("mis_wr_supp", 16'h0002, 16'hAAAA, 1'b0);
`else
    rd4_check("odd_rd", 16'h0003, 16'hAAAA, 1'b0);
    wr4_word(16'h0003, 16'h5555);
    rd4_check("odd_wr", 16'h0002, 16'h5555, 1'b0);
`endif

    // LATENCY=1: data in the cycle right after acceptance
    en1 = 1'b1; wr1 = 1'b1; addr1 = 16'h0040; din1 = 16'h0101; step();
    chk("l1_wr_dv", dv1, 1'b0);
    en1 = 1'b1; wr1 = 1'b0; addr1 = 16'h0040; step();
    en1 = 1'b0;
    chk("l1_rd_dv", dv1, 1'b1);
    chk("l1_rd_d", dout1, 16'h0101);
    chk("l1_rd_outst", outst1, 4'd1);
    step();
    chk("l1_idle_dv", dv1, 1'b0);
    chk("l1_idle_outst", outst1, 4'd0);
    chk("l1_hold", dout1, 16'h0101);

    // LATENCY=1: write/read/write/read every cycle
    en1 = 1'b1;
    wr1 = 1'b1; addr1 = 16'h0042; din1 = 16'h0202; step();
    chk("il_w1_dv", dv1, 1'b0);
    wr1 = 1'b0; addr1 = 16'h0042; step();
    chk("il_r1_dv", dv1, 1'b1);
    chk("il_r1_d", dout1, 16'h0202);
    wr1 = 1'b1; addr1 = 16'h0044; din1 = 16'h0303; step();
    chk("il_w2_dv", dv1, 1'b0);
    chk("il_w2_outst", outst1, 4'd0);
    wr1 = 1'b0; addr1 = 16'h0044; step();
    en1 = 1'b0;
    chk("il_r2_dv", dv1, 1'b1);
    chk("il_r2_d", dout1, 16'h0303);
    step();
    chk("il_end_dv", dv1, 1'b0);
    chk("il_end_outst", outst1, 4'd0);

    // ---------------- report ----------------
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
